// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: shared encodings for the SRAM stream arbiter/sequencer
package sram_ctrl_pkg;
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_t;
   localparam int   ACC_MIN    = 4;
   localparam int   ACC_MAX    = 15;
   localparam logic MODE_READ  = 1'b1;
   localparam logic MODE_WRITE = 1'b0;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin grant; last_grant resets to 1 so port 0 wins the first tie
module rr_arb2 (
   input  logic CLK,
   input  logic RSTn,
   input  logic req0,
   input  logic req1,
   input  logic upd,
   output logic gnt0,
   output logic gnt1
);
   logic last_grant;
   // a lone requester always wins; on a tie the port not served last wins
   always_comb begin
      gnt0 = req0 & (~req1 | last_grant);
      gnt1 = req1 & (~req0 | ~last_grant);
   end
   // remember which port was served at each accepted handshake
   always_ff @(posedge CLK)
      if (!RSTn) last_grant <= 1'b1;
      else if (upd) last_grant <= gnt1;
endmodule

// File: rtl/sram_arb_ctrl.sv
// sram_arb_ctrl: round-robin two-master arbiter and fixed-timing SRAM stream access sequencer
module sram_arb_ctrl
   import sram_ctrl_pkg::*;
#(
   parameter int ADDRW   = 20,
   parameter int DATAW   = 16,
   parameter int ACC_CYC = 4
) (
   input  logic             CLK,
   input  logic             RSTn,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic             req0_we,
   input  logic [ADDRW-1:0] req0_addr,
   input  logic [DATAW-1:0] req0_wdata,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic             req1_we,
   input  logic [ADDRW-1:0] req1_addr,
   input  logic [DATAW-1:0] req1_wdata,
   output logic             rsp0_valid,
   output logic             rsp1_valid,
   output logic [DATAW-1:0] rsp_rdata,
   output logic             sram_mode_R1_W0,
   output logic [ADDRW-1:0] sram_addr,
   output logic [DATAW-1:0] sram_wdata,
   input  logic [DATAW-1:0] sram_rdata
);
   if (ACC_CYC < ACC_MIN || ACC_CYC > ACC_MAX) begin : g_bad_acc_cyc
      $error("sram_arb_ctrl: ACC_CYC must be within 4..15");
   end
   // last ACCESS index, and last index whose successor cycle still strobes a write
   localparam logic [3:0] A_LAST = 4'(ACC_CYC - 1);
   localparam logic [3:0] W_LAST = 4'(ACC_CYC - 3);
   state_t     state;
   logic [3:0] cnt;
   logic       lat_we;
   logic       lat_port;
   logic       gnt0;
   logic       gnt1;
   logic       hs;
   rr_arb2 u_arb (
      .CLK  (CLK),
      .RSTn (RSTn),
      .req0 (req0_valid),
      .req1 (req1_valid),
      .upd  (hs),
      .gnt0 (gnt0),
      .gnt1 (gnt1)
   );
   // ready only while idle and out of reset; grants already imply valid
   always_comb begin
      req0_ready = RSTn & (state == ST_IDLE) & gnt0;
      req1_ready = RSTn & (state == ST_IDLE) & gnt1;
      hs         = req0_ready | req1_ready;
   end
   // sequencer: latch on handshake, time the strobe in ACCESS, pulse the response in RESP
   always_ff @(posedge CLK)
      if (!RSTn) begin
         state           <= ST_IDLE;
         cnt             <= '0;
         lat_we          <= 1'b0;
         lat_port        <= 1'b0;
         rsp0_valid      <= 1'b0;
         rsp1_valid      <= 1'b0;
         rsp_rdata       <= '0;
         sram_mode_R1_W0 <= MODE_READ;
         sram_addr       <= '0;
         sram_wdata      <= '0;
      end else begin
         case (state)
            ST_IDLE:
               if (hs) begin
                  lat_we     <= gnt1 ? req1_we : req0_we;
                  lat_port   <= gnt1;
                  sram_addr  <= gnt1 ? req1_addr : req0_addr;
                  sram_wdata <= gnt1 ? req1_wdata : req0_wdata;
                  cnt        <= '0;
                  state      <= ST_ACCESS;
               end
            ST_ACCESS:
               if (cnt == A_LAST) begin
                  state           <= ST_RESP;
                  sram_mode_R1_W0 <= MODE_READ;
                  rsp0_valid      <= ~lat_port;
                  rsp1_valid      <= lat_port;
                  if (!lat_we) rsp_rdata <= sram_rdata;
               end else begin
                  cnt             <= cnt + 4'd1;
                  sram_mode_R1_W0 <= (lat_we && cnt <= W_LAST) ? MODE_WRITE : MODE_READ;
               end
            ST_RESP: begin
               rsp0_valid <= 1'b0;
               rsp1_valid <= 1'b0;
               state      <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
endmodule

// File: tb/tb_sram_arb_ctrl.sv
// tb_sram_arb_ctrl: directed checks of arbitration, access timing and reset abort
module tb_sram_arb_ctrl;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        req0_valid, req0_ready, req0_we;
   logic [19:0] req0_addr;
   logic [15:0] req0_wdata;
   logic        req1_valid, req1_ready, req1_we;
   logic [19:0] req1_addr;
   logic [15:0] req1_wdata;
   logic        rsp0_valid, rsp1_valid;
   logic [15:0] rsp_rdata;
   logic        sram_mode;
   logic [19:0] sram_addr;
   logic [15:0] sram_wdata;
   logic [15:0] sram_rdata = 16'h0;
   logic [15:0] mem [logic [19:0]];
   int          vectors = 0;
   int          miscompares = 0;

   always #5 clk = ~clk;

   sram_arb_ctrl #(.ADDRW(20), .DATAW(16), .ACC_CYC(4)) dut (
      .CLK             (clk),
      .RSTn            (rst_n),
      .req0_valid      (req0_valid),
      .req0_ready      (req0_ready),
      .req0_we         (req0_we),
      .req0_addr       (req0_addr),
      .req0_wdata      (req0_wdata),
      .req1_valid      (req1_valid),
      .req1_ready      (req1_ready),
      .req1_we         (req1_we),
      .req1_addr       (req1_addr),
      .req1_wdata      (req1_wdata),
      .rsp0_valid      (rsp0_valid),
      .rsp1_valid      (rsp1_valid),
      .rsp_rdata       (rsp_rdata),
      .sram_mode_R1_W0 (sram_mode),
      .sram_addr       (sram_addr),
      .sram_wdata      (sram_wdata),
      .sram_rdata      (sram_rdata)
   );

   // asynchronous SRAM peripheral model: write while strobe low, registered read data
   always @(posedge clk) begin
      if (!sram_mode) mem[sram_addr] = sram_wdata;
      sram_rdata <= mem.exists(sram_addr) ? mem[sram_addr] : 16'h0;
   end

   // the strobe must be inactive whenever a response is being pulsed
   always @(negedge clk)
      if (rst_n && (rsp0_valid || rsp1_valid)) begin
         vectors++;
         assert (sram_mode === 1'b1)
            else begin miscompares++; $error("FAIL mode_in_resp observed=%b expected=1", sram_mode); end
      end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
         else begin miscompares++; $error("FAIL %s observed=%h expected=%h", tag, obs, exp); end
   endtask

   task automatic drive(input int p, input logic v, input logic we, input logic [19:0] a, input logic [15:0] d);
      if (p == 0) begin req0_valid = v; req0_we = we; req0_addr = a; req0_wdata = d; end
      else begin req1_valid = v; req1_we = we; req1_addr = a; req1_wdata = d; end
   endtask

   // one transaction from the IDLE negedge through to the following IDLE negedge
   task automatic txn(input int p, input logic we, input logic [19:0] a, input logic [15:0] d);
      drive(p, 1'b1, we, a, d);
      #1;
      chk("ready_own", p == 0 ? req0_ready : req1_ready, 1);
      chk("ready_other", p == 0 ? req1_ready : req0_ready, 0);
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         if (k == 1) drive(p, 1'b0, ~we, ~a, ~d);
         if (k <= 4) chk("mode", sram_mode, (we && k >= 2 && k <= 3) ? 0 : 1);
         if (k <= 4) chk("ready_busy", req0_ready | req1_ready, 0);
         chk("sram_addr", sram_addr, a);
         if (we && k <= 4) chk("sram_wdata", sram_wdata, d);
         chk("rsp0", rsp0_valid, (k == 5 && p == 0) ? 1 : 0);
         chk("rsp1", rsp1_valid, (k == 5 && p == 1) ? 1 : 0);
      end
      @(negedge clk);
      chk("rsp_clear", rsp0_valid | rsp1_valid, 0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      mem[20'h00012] = 16'hBEEF;
      drive(0, 1'b1, 1'b0, 20'h00012, 16'h0);
      drive(1, 1'b1, 1'b0, 20'h00034, 16'h0);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_ready", {req0_ready, req1_ready}, 0);
      chk("rst_rsp", {rsp0_valid, rsp1_valid}, 0);
      chk("rst_mode", sram_mode, 1);
      chk("rst_addr", sram_addr, 0);
      chk("rst_wdata", sram_wdata, 0);
      chk("rst_rdata", rsp_rdata, 0);
      drive(0, 1'b0, 1'b0, 20'h0, 16'h0);
      drive(1, 1'b0, 1'b0, 20'h0, 16'h0);
      rst_n = 1'b1;
      @(negedge clk);

      // single read on port 0
      txn(0, 1'b0, 20'h00012, 16'h0);
      chk("read_rdata", rsp_rdata, 16'hBEEF);

      // single write on port 1 to the top address
      txn(1, 1'b1, 20'hFFFFF, 16'h1234);
      chk("write_mem", mem[20'hFFFFF], 16'h1234);
      chk("write_keeps_rdata", rsp_rdata, 16'hBEEF);

      // both ports valid continuously: alternating grants every 6 cycles
      do_reset();
      drive(0, 1'b1, 1'b0, 20'h00012, 16'h0);
      drive(1, 1'b1, 1'b0, 20'h00012, 16'h0);
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("rr_ready0", req0_ready, (i % 2 == 0) ? 1 : 0);
         chk("rr_ready1", req1_ready, (i % 2 == 1) ? 1 : 0);
         repeat (5) @(negedge clk);
         chk("rr_rsp0", rsp0_valid, (i % 2 == 0) ? 1 : 0);
         chk("rr_rsp1", rsp1_valid, (i % 2 == 1) ? 1 : 0);
         @(negedge clk);
      end
      drive(0, 1'b0, 1'b0, 20'h0, 16'h0);
      drive(1, 1'b0, 1'b0, 20'h0, 16'h0);

      // rotation: port 0 served, then a tie goes to port 1 before port 0
      do_reset();
      txn(0, 1'b0, 20'h00012, 16'h0);
      drive(0, 1'b1, 1'b0, 20'h00012, 16'h0);
      drive(1, 1'b1, 1'b0, 20'h00012, 16'h0);
      #1;
      chk("rot_first_p1", {req1_ready, req0_ready}, 2'b10);
      repeat (6) @(negedge clk);
      #1;
      chk("rot_then_p0", {req1_ready, req0_ready}, 2'b01);
      repeat (6) @(negedge clk);
      drive(0, 1'b0, 1'b0, 20'h0, 16'h0);
      drive(1, 1'b0, 1'b0, 20'h0, 16'h0);
      @(negedge clk);

      // reset during ACCESS a1 of a port 0 write aborts it
      drive(0, 1'b1, 1'b1, 20'h00200, 16'h5555);
      @(negedge clk);
      drive(0, 1'b0, 1'b0, 20'h0, 16'h0);
      @(negedge clk);
      chk("abort_strobe", sram_mode, 0);
      rst_n = 1'b0;
      @(negedge clk);
      chk("abort_mode", sram_mode, 1);
      chk("abort_addr", sram_addr, 0);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("abort_no_rsp", {rsp0_valid, rsp1_valid}, 0);
      end
      drive(0, 1'b1, 1'b0, 20'h00012, 16'h0);
      drive(1, 1'b1, 1'b0, 20'h00012, 16'h0);
      #1;
      chk("after_reset_p0", {req1_ready, req0_ready}, 2'b01);
      repeat (6) @(negedge clk);
      drive(0, 1'b0, 1'b0, 20'h0, 16'h0);
      drive(1, 1'b0, 1'b0, 20'h0, 16'h0);
      repeat (6) @(negedge clk);

      // write then read back the same address
      txn(0, 1'b1, 20'h00100, 16'hA5A5);
      chk("wr_mem", mem[20'h00100], 16'hA5A5);
      txn(1, 1'b0, 20'h00100, 16'h0);
      chk("rd_back", rsp_rdata, 16'hA5A5);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/sram_arb_ctrl.md
Name: sram_arb_ctrl

Overview:
Two-requester arbiter and access sequencer for the external asynchronous SRAM stream peripheral.
- Accepts read and write requests from two masters over valid/ready handshakes and arbitrates them round-robin.
- Drives the peripheral's stream inputs (mode, address, write data) with fixed access timing and returns read data or a write acknowledge to the winning master.
- Sits between the bus-side masters and the SRAM pin driver; it is the only block that drives the SRAM stream side.

Parameters:
ADDRW, 20, address width in bits.
DATAW, 16, data width in bits.
ACC_CYC, 4, length of the ACCESS phase in cycles; legal values are 4 to 15, checked at elaboration.

Ports:
CLK  in  1  system clock, rising edge.
RSTn  in  1  synchronous active-low reset.
req0_valid / req1_valid  in  1  request present on port 0 / 1.
req0_ready / req1_ready  out  1  request accepted this cycle.
req0_we / req1_we  in  1  1 = write, 0 = read.
req0_addr / req1_addr  in  ADDRW  word address.
req0_wdata / req1_wdata  in  DATAW  write data.
rsp0_valid / rsp1_valid  out  1  one-cycle completion pulse for port 0 / 1.
rsp_rdata  out  DATAW  read data; holds its value until the next read completes.
sram_mode_R1_W0  out  1  to peripheral; 1 = read or idle, 0 = write strobe.
sram_addr  out  ADDRW  to peripheral stream address.
sram_wdata  out  DATAW  to peripheral stream write data.
sram_rdata  in  DATAW  from peripheral registered read data.

Behaviour:
- All state changes on the rising edge of CLK. RSTn=0 at an edge forces:
  - state to IDLE;
  - rsp0_valid, rsp1_valid and req*_ready to 0;
  - rsp_rdata, sram_addr and sram_wdata to 0;
  - sram_mode_R1_W0 to 1;
  - last_grant to 1, so port 0 wins the first tie.
- State machine IDLE -> ACCESS -> RESP -> IDLE.
- IDLE:
  - Grant: if only one reqN_valid is high, that port is granted. If both are high, grant goes to the port that is not last_grant.
  - reqN_ready = (state==IDLE) & grantN, combinational. A handshake is valid&ready in the same cycle.
  - On a handshake: latch we, addr, wdata and port id; update last_grant; cnt <= 0; go to ACCESS.
  - ready is 0 in every other state.
- ACCESS, cycle index a = cnt from 0 to ACC_CYC-1:
  - sram_addr and sram_wdata hold the latched values for the whole phase.
  - Write: sram_mode_R1_W0 = 0 only for 1 <= a <= ACC_CYC-2, and 1 otherwise. This gives address setup in a0, and the write-data register loads during the strobe.
  - Read: sram_mode_R1_W0 = 1 throughout. At the edge ending a = ACC_CYC-1, rsp_rdata <= sram_rdata.
  - At the edge ending a = ACC_CYC-1, go to RESP.
- RESP:
  - rspN_valid = 1 for exactly this one cycle, on the latched port id only, for both reads and writes.
  - sram_mode_R1_W0 = 1; sram_addr holds.
  - Next state is IDLE.
- Occupancy is ACC_CYC+2 cycles per transaction. Back-to-back requests are accepted in the IDLE cycle immediately after RESP.
- Masters may change or drop valid before ready without effect. Request fields are sampled only at the handshake.
- Writes leave rsp_rdata unchanged.
- Reset during ACCESS or RESP aborts the transaction: no rsp pulse, and sram_mode_R1_W0 returns to 1 in the next cycle.
- sram_mode_R1_W0 is never 0 outside ACCESS.

Decomposition:
- Shared package sram_ctrl_pkg holds:
  - state encoding constants ST_IDLE, ST_ACCESS, ST_RESP;
  - constants for the minimum and maximum ACC_CYC;
  - the MODE_READ=1 and MODE_WRITE=0 encodings.
- One natural sub-module, rr_arb2: a 2-way round-robin grant with a last_grant register and an update enable.
- The FSM and datapath registers stay in the top module.

Test Plan:
- Reset then single read: req0 read addr 0x00012, SRAM model returns 0xBEEF -> req0_ready high in cycle 0; sram_mode_R1_W0 stays 1; rsp0_valid pulses in cycle 5; rsp_rdata=0xBEEF.
- Single write on port 1, addr 0xFFFFF, data 0x1234, ACC_CYC=4 -> mode=0 exactly in ACCESS cycles a1–a2; sram_addr=0xFFFFF through ACCESS; model memory[0xFFFFF]=0x1234; rsp1_valid pulses once; rsp_rdata unchanged.
- Both ports hold valid continuously for 4 transactions -> grants go 0,1,0,1; accepts are spaced 6 cycles apart; each rsp pulse lands on the correct port.
- Port 1 alone requests after a port 0 grant, then both request -> port 1 is served first, then port 0 (last_grant rotation).
- RSTn asserted in ACCESS cycle a1 of a write -> no rsp pulse; mode=1 from the next cycle; first request after reset goes to port 0.
- Write 0xA5A5 to 0x00100, then read 0x00100 -> rsp_rdata=0xA5A5; sram_mode_R1_W0 is never 0 in IDLE or RESP (assertion).
